// File: rtl/vid_pkg.sv
// Shared types and default 640x480 timing for the raster timing generator.
// Counters are 12 bits wide, so each axis total must stay within 4096.
package vid_pkg;
    localparam int CNT_W = 12;

    typedef logic [CNT_W-1:0] vid_cnt_t;

    typedef struct packed {
        logic hsync;
        logic hblank;
        logic vsync;
        logic vblank;
        logic enable;
    } vid_timing_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic vid_cnt_t wrap_inc(input vid_cnt_t c, input vid_cnt_t last);
        return (c == last) ? '0 : c + vid_cnt_t'(1);
    endfunction
endpackage

// File: rtl/vid_axis_cnt.sv
// One raster axis: wrapping counter plus blank/sync decode of its next value.
// Advances on adv with no stall path; wrap is a same-cycle carry into the next axis.
module vid_axis_cnt
    import vid_pkg::*;
#(
    parameter int ACTIVE   = DEF_H_ACTIVE,
    parameter int FP       = DEF_H_FP,
    parameter int SYNC     = DEF_H_SYNC,
    parameter int BP       = DEF_H_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     adv,
    output vid_cnt_t cnt,
    output vid_cnt_t cnt_nxt,
    output logic     blank_nxt,
    output logic     sync_nxt,
    output logic     wrap
);
    localparam int       TOTAL   = ACTIVE + FP + SYNC + BP;
    localparam vid_cnt_t LAST    = vid_cnt_t'(TOTAL - 1);
    localparam vid_cnt_t ACT_END = vid_cnt_t'(ACTIVE);
    localparam vid_cnt_t SYNC_LO = vid_cnt_t'(ACTIVE + FP);
    localparam vid_cnt_t SYNC_HI = vid_cnt_t'(ACTIVE + FP + SYNC);

    logic sync_act;

    assign wrap    = adv && (cnt == LAST);
    assign cnt_nxt = adv ? wrap_inc(cnt, LAST) : cnt;

    assign blank_nxt = (cnt_nxt >= ACT_END);
    assign sync_act  = (cnt_nxt >= SYNC_LO) && (cnt_nxt < SYNC_HI);
    assign sync_nxt  = SYNC_POL ? sync_act : !sync_act;

    // Reset parks on the last position so the first advance lands on 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= LAST;
        end else begin
            cnt <= cnt_nxt;
        end
    end
endmodule

// File: rtl/vid_timing_gen.sv
// Raster sync/blank/enable generator; outputs registered from next-state decode (0-cycle skew).
// Paced only by pix_ce, no backpressure; VID_TIMING_PREFETCH_EN adds the early line_req.
module vid_timing_gen
    import vid_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int PREFETCH  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    output logic        hsync,
    output logic        hblank,
    output logic        vsync,
    output logic        vblank,
    output logic        enable,
    output logic [11:0] hcount,
    output logic [11:0] vcount,
    output logic        frame_start,
    output logic        line_req,
    output logic [11:0] line_req_num
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam vid_timing_t TIMING_RST = '{hsync: !HSYNC_POL, hblank: 1'b1,
                                           vsync: !VSYNC_POL, vblank: 1'b1,
                                           enable: 1'b0};

    if (H_BP < 1 || V_BP < 1 || H_TOTAL > 4096 || V_TOTAL > 4096 ||
        PREFETCH < 1 || PREFETCH >= H_TOTAL) begin : g_bad_cfg
        $error("vid_timing_gen: invalid timing parameters");
    end

    vid_cnt_t    h_nxt;
    vid_cnt_t    v_nxt;
    logic        h_blank_nxt, h_sync_nxt, h_wrap;
    logic        v_blank_nxt, v_sync_nxt, v_wrap;
    vid_timing_t timing_nxt;
    vid_timing_t timing_q;

    vid_axis_cnt #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(HSYNC_POL)
    ) u_h (
        .clk(clk), .reset(reset), .adv(pix_ce),
        .cnt(hcount), .cnt_nxt(h_nxt),
        .blank_nxt(h_blank_nxt), .sync_nxt(h_sync_nxt), .wrap(h_wrap)
    );

    // The vertical axis only steps on a line wrap, so vsync/vblank move only as hcount hits 0.
    vid_axis_cnt #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(VSYNC_POL)
    ) u_v (
        .clk(clk), .reset(reset), .adv(h_wrap),
        .cnt(vcount), .cnt_nxt(v_nxt),
        .blank_nxt(v_blank_nxt), .sync_nxt(v_sync_nxt), .wrap(v_wrap)
    );

    always_comb begin
        timing_nxt = '{hsync: h_sync_nxt, hblank: h_blank_nxt,
                       vsync: v_sync_nxt, vblank: v_blank_nxt,
                       enable: !h_blank_nxt && !v_blank_nxt};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timing_q    <= TIMING_RST;
            frame_start <= 1'b0;
        end else begin
            if (pix_ce) begin
                timing_q <= timing_nxt;
            end
            frame_start <= v_wrap;
        end
    end

    assign hsync  = timing_q.hsync;
    assign hblank = timing_q.hblank;
    assign vsync  = timing_q.vsync;
    assign vblank = timing_q.vblank;
    assign enable = timing_q.enable;

`ifdef VID_TIMING_PREFETCH_EN
    localparam vid_cnt_t REQ_H  = vid_cnt_t'(H_TOTAL - PREFETCH);
    localparam vid_cnt_t V_LAST = vid_cnt_t'(V_TOTAL - 1);
    localparam vid_cnt_t V_ACT  = vid_cnt_t'(V_ACTIVE);

    vid_cnt_t req_line;
    logic     req_fire;

    // REQ_H is never 0, so vcount is stable on the request edge.
    assign req_line = wrap_inc(vcount, V_LAST);
    assign req_fire = pix_ce && (h_nxt == REQ_H) && (req_line < V_ACT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_req     <= 1'b0;
            line_req_num <= '0;
        end else begin
            line_req <= req_fire;
            if (req_fire) begin
                line_req_num <= req_line;
            end
        end
    end
`else
    assign line_req     = 1'b0;
    assign line_req_num = '0;
`endif
endmodule
